key_refresh_scheduler: RTL and testbench

- Sequences the periodic randomness refresh of the masked long-term key holder between AES executions.
- Sits between the PRNG randomness port, the AES core start handshake and the key holder.
- Counts completed executions and, once REFRESH_PERIOD is reached (or on request), streams exactly one full key rotation's worth of fresh randomness words into the holder.
- Blocks new AES starts while a refresh is pending or running.

---
 rtl/key_refresh_scheduler_pkg.sv | 22 ++
 rtl/key_refresh_scheduler_if.sv | 37 +++
 rtl/key_refresh_scheduler_refresh_word_counter.sv | 29 ++
 rtl/key_refresh_scheduler.sv | 107 ++++++++++
 tb/tb_key_refresh_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_refresh_scheduler_pkg.sv
// Shared definitions for the key refresh scheduler: FSM state encoding and
// helpers that derive the rotation length and counter widths from the key
// geometry.
package key_refresh_scheduler_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_SAFE = 2'd1;
  localparam logic [1:0] ST_REFRESH   = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  // Number of randomness words in one full key rotation.
  function automatic int calc_n_words(input int key_bits, input int rate);
    return key_bits / rate;
  endfunction

  // Counter width able to index n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_refresh_scheduler_if.sv
// Handshake bundle around the key refresh scheduler: PRNG randomness port,
// key holder refresh port, AES start handshake and refresh status.
interface key_refresh_scheduler_if #(
  parameter int D          = 2,
  parameter int RFRSH_RATE = 16
);

  localparam int RND_W = (D - 1) * RFRSH_RATE;

  logic [RND_W-1:0] rnd_in;
  logic             rnd_in_valid;
  logic             rnd_in_ready;
  logic [RND_W-1:0] rnd_rfrsh_out;
  logic             rnd_rfrsh_out_valid;
  logic             aes_busy;
  logic             aes_start_req;
  logic             aes_start_grant;
  logic             kh_busy;
  logic             force_refresh;
  logic             refresh_busy;
  logic             refresh_done;

  // Environment side: PRNG, AES core, key holder and control.
  modport master (
    output rnd_in, rnd_in_valid, aes_busy, aes_start_req, kh_busy, force_refresh,
    input  rnd_in_ready, rnd_rfrsh_out, rnd_rfrsh_out_valid, aes_start_grant,
           refresh_busy, refresh_done
  );

  // Scheduler side.
  modport slave (
    input  rnd_in, rnd_in_valid, aes_busy, aes_start_req, kh_busy, force_refresh,
    output rnd_in_ready, rnd_rfrsh_out, rnd_rfrsh_out_valid, aes_start_grant,
           refresh_busy, refresh_done
  );

endinterface

// File: rtl/key_refresh_scheduler_refresh_word_counter.sv
// Serial fetch word counter: counts enabled cycles from 0 to N-1, wraps
// explicitly at the terminal value and flags it with tc.
module refresh_word_counter
  import key_refresh_scheduler_pkg::*;
#(
  parameter int N = 16,
  parameter int W = cnt_width(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  // Count enabled words; clear has priority and the wrap is explicit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tc ? '0 : cnt + W'(1);
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/key_refresh_scheduler.sv
// Schedules the periodic randomness refresh of the masked key holder between
// AES executions. Counts completed executions, and after REFRESH_PERIOD of
// them (or on force_refresh) waits until AES and key holder are quiet, then
// streams one full rotation of PRNG words into the holder. New AES starts are
// withheld while a refresh is pending or running.
module key_refresh_scheduler
  import key_refresh_scheduler_pkg::*;
#(
  parameter int d              = 2,
  parameter int RFRSH_RATE     = 16,
  parameter int KEY_BITS       = 256,
  parameter int REFRESH_PERIOD = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  key_refresh_scheduler_if.slave   bus
);

  localparam int N_WORDS = calc_n_words(KEY_BITS, RFRSH_RATE);
  localparam int CNT_W   = cnt_width(N_WORDS);
  localparam int EXEC_W  = $clog2(REFRESH_PERIOD + 1);

  localparam logic [EXEC_W-1:0] EXEC_LAST = EXEC_W'(REFRESH_PERIOD - 1);

  logic [1:0]        state, state_d;
  logic [EXEC_W-1:0] exec_cnt, exec_cnt_d;
  logic              prev_aes_busy;
  logic              exec_end;
  logic              word_en;
  logic              word_clr;
  logic              word_tc;

  // Delayed copy of aes_busy used to find the end of an execution.
  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_aes_busy <= 1'b0;
    else      prev_aes_busy <= bus.aes_busy;
  end

  assign exec_end = prev_aes_busy & ~bus.aes_busy;

  // Next-state and execution-count logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d    = state;
    exec_cnt_d = exec_cnt;
    case (state)
      ST_IDLE: begin
        if (bus.force_refresh) begin
          exec_cnt_d = '0;
          state_d    = ST_WAIT_SAFE;
        end else if (exec_end) begin
          if (exec_cnt == EXEC_LAST) begin
            exec_cnt_d = '0;
            state_d    = ST_WAIT_SAFE;
          end else begin
            exec_cnt_d = exec_cnt + EXEC_W'(1);
          end
        end
      end
      ST_WAIT_SAFE: begin
        if (!bus.aes_busy && !bus.kh_busy) state_d = ST_REFRESH;
      end
      ST_REFRESH: begin
        if (bus.rnd_in_valid && word_tc) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and execution-count registers; a reset abandons any partial rotation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      exec_cnt <= '0;
    end else begin
      state    <= state_d;
      exec_cnt <= exec_cnt_d;
    end
  end

  assign word_en  = (state == ST_REFRESH) & bus.rnd_in_valid;
  assign word_clr = (state != ST_REFRESH);

  refresh_word_counter #(
    .N (N_WORDS),
    .W (CNT_W)
  ) u_word_cnt (
    .clk (clk),
    .rst (rst),
    .en  (word_en),
    .clr (word_clr),
    .tc  (word_tc)
  );

  assign bus.rnd_in_ready        = (state == ST_REFRESH);
  assign bus.rnd_rfrsh_out_valid = (state == ST_REFRESH) & bus.rnd_in_valid;
  // Randomness passes straight through, but is forced quiet while in reset.
  assign bus.rnd_rfrsh_out       = rst ? bus.rnd_in : '0;
  assign bus.refresh_busy        = (state != ST_IDLE);
  assign bus.refresh_done        = (state == ST_DONE);
  // A refresh trigger in the same cycle as a start request wins.
  assign bus.aes_start_grant     = rst & bus.aes_start_req & (state == ST_IDLE) &
                                   ~exec_end & ~bus.force_refresh &
                                   ~bus.kh_busy & ~bus.aes_busy;

endmodule

// File: tb/tb_key_refresh_scheduler.sv
// Self-checking bench for key_refresh_scheduler. Two instances (period 1 and
// period 3) see identical stimulus; each is compared every cycle against a
// behavioural model, plus a directed vector table and corner-case sequences.
module tb_key_refresh_scheduler;

  localparam int D        = 2;
  localparam int RATE     = 16;
  localparam int KEY_BITS = 256;
  localparam int N_WORDS  = KEY_BITS / RATE;
  localparam int W        = (D - 1) * RATE;
  localparam int OW       = W + 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] rnd_in = '0;
  logic         rnd_in_valid = 1'b0;
  logic         aes_busy = 1'b0;
  logic         aes_start_req = 1'b0;
  logic         kh_busy = 1'b0;
  logic         force_refresh = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  key_refresh_scheduler_if #(.D(D), .RFRSH_RATE(RATE)) bus1 ();
  key_refresh_scheduler_if #(.D(D), .RFRSH_RATE(RATE)) bus3 ();

  assign bus1.rnd_in = rnd_in;         assign bus3.rnd_in = rnd_in;
  assign bus1.rnd_in_valid = rnd_in_valid;  assign bus3.rnd_in_valid = rnd_in_valid;
  assign bus1.aes_busy = aes_busy;     assign bus3.aes_busy = aes_busy;
  assign bus1.aes_start_req = aes_start_req; assign bus3.aes_start_req = aes_start_req;
  assign bus1.kh_busy = kh_busy;       assign bus3.kh_busy = kh_busy;
  assign bus1.force_refresh = force_refresh; assign bus3.force_refresh = force_refresh;

  key_refresh_scheduler #(.d(D), .RFRSH_RATE(RATE), .KEY_BITS(KEY_BITS),
    .REFRESH_PERIOD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  key_refresh_scheduler #(.d(D), .RFRSH_RATE(RATE), .KEY_BITS(KEY_BITS),
    .REFRESH_PERIOD(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  // ---------------- behavioural model ----------------
  int m_left[2];   // words still to stream (0 = not streaming)
  bit m_pend[2];   // refresh triggered, waiting for a safe moment
  bit m_done[2];   // completion pulse this cycle
  int m_execs[2];  // executions seen since last refresh
  bit m_prev;
  int period[2] = '{1, 3};

  function automatic bit model_idle(input int k);
    return !m_pend[k] && (m_left[k] == 0) && !m_done[k];
  endfunction

  // Output order: {ready, out_valid, grant, busy, done, rnd_out}
  function automatic logic [OW-1:0] model_out(input int k);
    bit ee, rdy, vld, gnt;
    if (!rst) return '0;
    ee  = m_prev && !aes_busy;
    rdy = (m_left[k] > 0);
    vld = rdy && rnd_in_valid;
    gnt = aes_start_req && model_idle(k) && !ee && !force_refresh && !kh_busy && !aes_busy;
    return {rdy, vld, gnt, !model_idle(k), m_done[k], rnd_in};
  endfunction

  function automatic logic [OW-1:0] actual(input int k);
    if (k == 0)
      return {bus1.rnd_in_ready, bus1.rnd_rfrsh_out_valid, bus1.aes_start_grant,
              bus1.refresh_busy, bus1.refresh_done, bus1.rnd_rfrsh_out};
    return {bus3.rnd_in_ready, bus3.rnd_rfrsh_out_valid, bus3.aes_start_grant,
            bus3.refresh_busy, bus3.refresh_done, bus3.rnd_rfrsh_out};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_pend[k] = 0; m_done[k] = 0; m_execs[k] = 0;
    end
    m_prev = 0;
  endtask

  // Advance the model by one clock edge using the inputs of the ending cycle.
  task automatic model_edge();
    bit ee;
    if (!rst) begin
      model_reset();
      return;
    end
    ee = m_prev && !aes_busy;
    for (int k = 0; k < 2; k++) begin
      if (m_done[k]) begin
        m_done[k] = 0;
      end else if (m_left[k] > 0) begin
        if (rnd_in_valid) begin
          m_left[k]--;
          if (m_left[k] == 0) m_done[k] = 1;
        end
      end else if (m_pend[k]) begin
        if (!aes_busy && !kh_busy) begin
          m_pend[k] = 0;
          m_left[k] = N_WORDS;
        end
      end else if (force_refresh) begin
        m_pend[k]  = 1;
        m_execs[k] = 0;
      end else if (ee) begin
        m_execs[k]++;
        if (m_execs[k] == period[k]) begin
          m_execs[k] = 0;
          m_pend[k]  = 1;
        end
      end
    end
    m_prev = aes_busy;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances to the model, then advance one cycle.
  task automatic step();
    #1;
    check("model dut1", 64'(actual(0)), 64'(model_out(0)));
    check("model dut3", 64'(actual(1)), 64'(model_out(1)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic neutral();
    aes_busy = 0; aes_start_req = 0; kh_busy = 0; force_refresh = 0;
    rnd_in_valid = 1; rnd_in = W'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    neutral();
    for (int i = 0; i < 100; i++) begin
      if (model_idle(0) && model_idle(1)) begin
        ok = 1;
        break;
      end
      step();
    end
    check("wait_idle bound", 64'(ok), 64'(1));
  endtask

  task automatic exec_pulse(input bit exp3);
    neutral();
    aes_busy = 1;
    repeat (3) step();
    aes_busy = 0;
    step();
    #1;
    check("pulse busy dut3", 64'(bus3.refresh_busy), 64'(exp3));
    check("pulse busy dut1", 64'(bus1.refresh_busy), 64'(1));
    step();
    wait_idle();
  endtask

  task automatic force_pulse();
    force_refresh = 1;
    step();
    force_refresh = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         busy_in, req, vld;
    logic [W-1:0] rnd;
    logic         e_rdy, e_vld, e_gnt, e_busy, e_done;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [W-1:0] got[$];
    logic [W-1:0] exp_q[$];
    int           done_cnt;
    bit           done_after, seen;

    model_reset();
    // Period-1 refresh after a 5-cycle execution: row 5 is the exec_end cycle
    // (edge t), WAIT_SAFE at row 6, words 0..15 on rows 7..22, done on row 23.
    for (int c = 0; c < 26; c++) begin
      vec_t v;
      v.busy_in = (c < 5);
      v.req     = (c < 25);
      v.vld     = 1'b1;
      v.rnd     = (c >= 7 && c <= 22) ? W'(c - 7) : W'(16'hA5A5);
      v.e_rdy   = (c >= 7 && c <= 22);
      v.e_vld   = v.e_rdy;
      v.e_gnt   = (c == 24);
      v.e_busy  = (c >= 6 && c <= 23);
      v.e_done  = (c == 23);
      tbl.push_back(v);
    end

    @(negedge clk);

    // Reset with random inputs: every output quiet.
    for (int i = 0; i < 5; i++) begin
      rnd_in = W'($urandom); rnd_in_valid = 1'($urandom); aes_busy = 1'($urandom);
      aes_start_req = 1; kh_busy = 0; force_refresh = 1'($urandom);
      #1;
      check("reset outputs dut1", 64'(actual(0)), 64'(0));
      check("reset outputs dut3", 64'(actual(1)), 64'(0));
      step();
    end
    neutral();
    rst = 1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus1.rnd_in_ready || bus3.rnd_in_ready) seen = 1;
      step();
    end
    check("no ready without trigger", 64'(seen), 64'(0));

    // Table-driven period-1 refresh with a start request held throughout.
    foreach (tbl[i]) begin
      aes_busy = tbl[i].busy_in; aes_start_req = tbl[i].req;
      rnd_in_valid = tbl[i].vld; rnd_in = tbl[i].rnd;
      #1;
      check($sformatf("tbl[%0d]", i), 64'(actual(0)),
            64'({tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_gnt, tbl[i].e_busy,
                 tbl[i].e_done, tbl[i].rnd}));
      step();
    end
    wait_idle();

    // PRNG stall pattern: valid 1,0,0,... ; exactly 16 words, order kept.
    force_pulse();
    done_cnt = 0; done_after = 0;
    for (int i = 0; i < 80; i++) begin
      rnd_in_valid = (i % 3 == 0);
      rnd_in = W'(16'h100 + i);
      #1;
      if (bus1.rnd_rfrsh_out_valid) got.push_back(bus1.rnd_rfrsh_out);
      if (m_left[0] > 0 && rnd_in_valid) exp_q.push_back(rnd_in);
      if (bus1.refresh_done) begin
        done_cnt++;
        done_after = (got.size() == N_WORDS);
      end
      step();
    end
    check("stall word count", 64'(got.size()), 64'(N_WORDS));
    check("stall expected count", 64'(exp_q.size()), 64'(N_WORDS));
    for (int i = 0; i < N_WORDS && i < got.size() && i < exp_q.size(); i++)
      check($sformatf("stall word %0d", i), 64'(got[i]), 64'(exp_q[i]));
    check("stall done pulses", 64'(done_cnt), 64'(1));
    check("stall done after last", 64'(done_after), 64'(1));
    wait_idle();

    // Period-3: refresh only on the third execution; force clears the count.
    force_pulse();
    wait_idle();
    exec_pulse(0);
    exec_pulse(0);
    exec_pulse(1);
    exec_pulse(0);
    force_pulse();
    #1;
    check("force mid-count dut3", 64'(bus3.refresh_busy), 64'(1));
    step();
    wait_idle();
    exec_pulse(0);
    exec_pulse(0);
    wait_idle();

    // kh_busy holds WAIT_SAFE; then reset abandons a partial rotation.
    kh_busy = 1;
    force_pulse();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("kh hold ready", 64'(bus1.rnd_in_ready), 64'(0));
      check("kh hold busy", 64'(bus1.refresh_busy), 64'(1));
      step();
    end
    kh_busy = 0;
    #1;
    check("kh drop cycle ready", 64'(bus1.rnd_in_ready), 64'(0));
    step();
    #1;
    check("refresh after kh drop", 64'(bus1.rnd_in_ready), 64'(1));
    repeat (7) step();
    rst = 0;
    model_reset();
    #1;
    check("async reset dut1", 64'(actual(0)), 64'(0));
    check("async reset dut3", 64'(actual(1)), 64'(0));
    step();
    rst = 1;
    done_cnt = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus1.refresh_done || bus3.refresh_done) done_cnt++;
      if (bus1.refresh_busy || bus3.refresh_busy) seen = 1;
      step();
    end
    check("no done after reset", 64'(done_cnt), 64'(0));
    check("idle after reset", 64'(seen), 64'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) aes_busy = ~aes_busy;
      aes_start_req = 1'($urandom);
      force_refresh = ($urandom_range(0, 39) == 0);
      kh_busy       = ($urandom_range(0, 3) == 0);
      rnd_in_valid  = ($urandom_range(0, 3) != 0);
      rnd_in        = W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst = 0;
        model_reset();
      end else begin
        rst = 1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
